slice_logic_unit: RTL and testbench

Multi-cycle, parametrised bitwise logic unit for the ALU datapath. It is the successor to the single-bit OR primitive. It accepts two WIDTH-bit operands and a 2-bit opcode (AND/OR/XOR/NOR) under a start/busy/done handshake. It evaluates the operation SLICE bits per cycle, least-significant slice first, into a result register. A zero flag accompanies the result.

---
 rtl/slice_logic_unit_if.sv | 17 +
 rtl/slice_logic_unit.sv | 107 ++++++++++
 tb/tb_slice_logic_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/slice_logic_unit_if.sv
// Request/response bundle for slice_logic_unit: operands and opcode in,
// busy/done/result/zero out.
interface slice_logic_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (output start, op, a, b, input busy, done, result, zero);
  modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/slice_logic_unit.sv
// Multi-cycle bitwise logic unit: evaluates AND/OR/XOR/NOR SLICE bits per
// cycle, least-significant slice first, under a start/busy/done handshake.
module slice_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          clk,
  input  logic          reset,
  slice_logic_unit_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  generate
    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
      $error("slice_logic_unit: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NOR = 2'b11} op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  function automatic logic [SLICE-1:0] slice_op(input op_e o,
                                                input logic [SLICE-1:0] x,
                                                input logic [SLICE-1:0] y);
    case (o)
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path through this block can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_d     = op_e'(bus.op);
          a_d      = bus.a;
          b_d      = bus.b;
          result_d = '0;
          idx_d    = '0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Constant-indexed loop keeps the slice mux free of variable part-selects.
        for (int k = 0; k < NSLICE; k++) begin
          if (idx_q == IDXW'(k)) begin
            result_d[k*SLICE +: SLICE] = slice_op(op_q, a_q[k*SLICE +: SLICE], b_q[k*SLICE +: SLICE]);
          end
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.zero   = ~|result_q;

endmodule

// File: tb/tb_slice_logic_unit.sv
// Self-checking bench for slice_logic_unit: directed scenarios plus random
// operations, with SLICE=8, 32 and 1 instances sharing one stimulus.
module tb_slice_logic_unit;

  logic        clk = 1'b0;
  logic        reset_r = 1'b1;
  logic        start_r = 1'b0;
  logic [1:0]  op_r = 2'b00;
  logic [31:0] a_r = '0;
  logic [31:0] b_r = '0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  slice_logic_unit_if #(.WIDTH(32)) bus8 ();
  slice_logic_unit_if #(.WIDTH(32)) bus32 ();
  slice_logic_unit_if #(.WIDTH(32)) bus1 ();

  assign bus8.start  = start_r;
  assign bus8.op     = op_r;
  assign bus8.a      = a_r;
  assign bus8.b      = b_r;
  assign bus32.start = start_r;
  assign bus32.op    = op_r;
  assign bus32.a     = a_r;
  assign bus32.b     = b_r;
  assign bus1.start  = start_r;
  assign bus1.op     = op_r;
  assign bus1.a      = a_r;
  assign bus1.b      = b_r;

  slice_logic_unit #(.WIDTH(32), .SLICE(8))  dut8  (.clk(clk), .reset(reset_r), .bus(bus8.slave));
  slice_logic_unit #(.WIDTH(32), .SLICE(32)) dut32 (.clk(clk), .reset(reset_r), .bus(bus32.slave));
  slice_logic_unit #(.WIDTH(32), .SLICE(1))  dut1  (.clk(clk), .reset(reset_r), .bus(bus1.slave));

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start_r = 1'b1;
    op_r    = o;
    a_r     = x;
    b_r     = y;
  endtask

  // Called right after start is driven; scrambles inputs after the accept edge
  // and optionally pulses start again at sample inject_at.
  task automatic wait_done(input int inject_at, output int lat, output int busy_n,
                           output bit first_busy, output bit overlap,
                           output logic [31:0] res, output logic z);
    int cnt;
    cnt = 0;
    lat = -1; busy_n = 0; first_busy = 1'b0; overlap = 1'b0; res = 'x; z = 1'bx;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) begin
        start_r = 1'b0;
        op_r = 2'($urandom); a_r = $urandom; b_r = $urandom;
        first_busy = bus8.busy;
      end
      if (cnt == inject_at) begin
        start_r = 1'b1; op_r = 2'b00; a_r = '0;
      end else if (inject_at > 0 && cnt == inject_at + 1) begin
        start_r = 1'b0;
      end
      if (bus8.busy) busy_n++;
      if (bus8.busy && bus8.done) overlap = 1'b1;
      if (bus8.done) begin
        lat = cnt - 1; res = bus8.result; z = bus8.zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_r = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus8.busy); end
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus8.done); end
    total++; if (bus8.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus8.result); end
    total++; if (bus8.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%b want=1", bus8.zero); end
    total++; if (bus1.busy !== 1'b0 || bus32.busy !== 1'b0) begin bad++; $display("FAIL reset_sweep_busy got=%b%b want=00", bus1.busy, bus32.busy); end
    reset_r = 1'b0;
  endtask

  task automatic test_or();
    int lat, bn; bit fb, ov; logic [31:0] res; logic z;
    issue(2'b01, 32'hF0F0_0000, 32'h0F0F_00FF);
    wait_done(0, lat, bn, fb, ov, res, z);
    total++; if (lat !== 4) begin bad++; $display("FAIL or_latency got=%0d want=4", lat); end
    total++; if (bn !== 4) begin bad++; $display("FAIL or_busy_cycles got=%0d want=4", bn); end
    total++; if (res !== 32'hFFFF_00FF) begin bad++; $display("FAIL or_result got=%h want=ffff00ff", res); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL or_zero got=%b want=0", z); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL or_busy_done_overlap got=%b want=0", ov); end
    @(negedge clk);
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL or_done_width got=%b want=0", bus8.done); end
  endtask

  task automatic test_nor();
    int lat, bn; bit fb, ov; logic [31:0] res; logic z;
    issue(2'b11, 32'hFFFF_FFFF, 32'h0000_0000);
    wait_done(0, lat, bn, fb, ov, res, z);
    total++; if (lat !== 4) begin bad++; $display("FAIL nor_latency got=%0d want=4", lat); end
    total++; if (res !== 32'h0) begin bad++; $display("FAIL nor_result got=%h want=0", res); end
    total++; if (z !== 1'b1) begin bad++; $display("FAIL nor_zero got=%b want=1", z); end
  endtask

  task automatic test_ignore_start();
    int lat, bn, extra; bit fb, ov; logic [31:0] res; logic z;
    issue(2'b10, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    wait_done(2, lat, bn, fb, ov, res, z);
    total++; if (res !== 32'h5555_5555) begin bad++; $display("FAIL ignore_result got=%h want=55555555", res); end
    total++; if (lat !== 4) begin bad++; $display("FAIL ignore_latency got=%0d want=4", lat); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL ignore_extra_activity got=%0d want=0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; bit fb, ov; logic [31:0] res, x, y; logic z; logic [1:0] o;
    o = 2'($urandom); x = $urandom; y = $urandom;
    issue(o, x, y);
    wait_done(0, lat, bn, fb, ov, res, z);
    total++; if (res !== model(o, x, y)) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", res, model(o, x, y)); end
    start_r = 1'b1; op_r = 2'b00; a_r = 32'h1234_5678; b_r = 32'h0000_FFFF;
    wait_done(0, lat, bn, fb, ov, res, z);
    total++; if (fb !== 1'b1) begin bad++; $display("FAIL b2b_busy_rise got=%b want=1", fb); end
    total++; if (lat + 1 !== 5) begin bad++; $display("FAIL b2b_done_gap got=%0d want=5", lat + 1); end
    total++; if (res !== 32'h0000_5678) begin bad++; $display("FAIL b2b_result got=%h want=00005678", res); end
    @(negedge clk);
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL b2b_done_width got=%b want=0", bus8.done); end
  endtask

  task automatic test_reset_mid();
    int lat, bn, dn; bit fb, ov; logic [31:0] res; logic z;
    issue(2'b01, $urandom | 32'h1, $urandom);
    @(negedge clk);
    start_r = 1'b0;
    @(negedge clk);
    reset_r = 1'b1;
    @(negedge clk);
    reset_r = 1'b0;
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", bus8.busy); end
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got=%b want=0", bus8.done); end
    total++; if (bus8.result !== 32'h0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", bus8.result); end
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus8.done) dn++;
    end
    total++; if (dn !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dn); end
    issue(2'b01, 32'h1, 32'h2);
    wait_done(0, lat, bn, fb, ov, res, z);
    total++; if (res !== 32'h3) begin bad++; $display("FAIL rst_mid_after_result got=%h want=3", res); end
    total++; if (lat !== 4) begin bad++; $display("FAIL rst_mid_after_latency got=%0d want=4", lat); end
  endtask

  task automatic test_random();
    int lat, bn; bit fb, ov; logic [31:0] res, x, y, exp_r; logic z; logic [1:0] o;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom); x = $urandom; y = $urandom;
      if (i % 6 == 0) begin o = 2'b10; y = x; end
      exp_r = model(o, x, y);
      issue(o, x, y);
      wait_done(0, lat, bn, fb, ov, res, z);
      total++; if (res !== exp_r) begin bad++; $display("FAIL rand_result[%0d] op=%0d got=%h want=%h", i, o, res, exp_r); end
      total++; if (z !== (exp_r == 32'h0)) begin bad++; $display("FAIL rand_zero[%0d] got=%b want=%b", i, z, exp_r == 32'h0); end
      total++; if (lat !== 4 || bn !== 4 || ov) begin bad++; $display("FAIL rand_timing[%0d] lat=%0d busy=%0d overlap=%b want 4/4/0", i, lat, bn, ov); end
    end
  endtask

  task automatic test_sweep();
    int bn[3], lt[3], dc[3];
    logic [31:0] rs[3], r_arr[3];
    bit b_arr[3], d_arr[3];
    int exp_lat[3];
    exp_lat = '{4, 1, 32};
    for (int i = 0; i < 3; i++) begin bn[i] = 0; lt[i] = -1; dc[i] = 0; rs[i] = 'x; end
    reset_r = 1'b1;
    repeat (2) @(negedge clk);
    reset_r = 1'b0;
    start_r = 1'b1; op_r = 2'b10; a_r = 32'h0F0F_0F0F; b_r = 32'hFFFF_0000;
    for (int cnt = 1; cnt <= 45; cnt++) begin
      @(negedge clk);
      if (cnt == 1) begin start_r = 1'b0; a_r = $urandom; b_r = $urandom; end
      b_arr = '{bus8.busy, bus32.busy, bus1.busy};
      d_arr = '{bus8.done, bus32.done, bus1.done};
      r_arr = '{bus8.result, bus32.result, bus1.result};
      for (int i = 0; i < 3; i++) begin
        if (b_arr[i]) bn[i]++;
        if (d_arr[i]) begin
          dc[i]++;
          if (lt[i] < 0) begin lt[i] = cnt - 1; rs[i] = r_arr[i]; end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++; if (lt[i] !== exp_lat[i]) begin bad++; $display("FAIL sweep_latency[%0d] got=%0d want=%0d", i, lt[i], exp_lat[i]); end
      total++; if (bn[i] !== exp_lat[i]) begin bad++; $display("FAIL sweep_busy[%0d] got=%0d want=%0d", i, bn[i], exp_lat[i]); end
      total++; if (dc[i] !== 1) begin bad++; $display("FAIL sweep_done_count[%0d] got=%0d want=1", i, dc[i]); end
      total++; if (rs[i] !== 32'hF0F0_0F0F) begin bad++; $display("FAIL sweep_result[%0d] got=%h want=f0f00f0f", i, rs[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_or();
    test_nor();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
